// File: rtl/data_mem_be_if.sv
// Request/response bus between the core's memory stage and the byte-enabled data memory.
// The master issues loads/stores; the slave returns one in-order response per accepted request.
interface data_mem_be_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_is_load;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_is_load, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_is_load, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_be.sv
// Byte-addressed RISC-V data memory: SB/SH/SW and LB/LH/LW/LBU/LHU decoded from funct3,
// with lane steering, sign/zero extension, error detection and a 1- or 2-cycle response.
module data_mem_be #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    data_mem_be_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("data_mem_be: READ_LATENCY must be 1 or 2");
        end
        if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
            $error("data_mem_be: DEPTH_WORDS must be a power of two >= 4");
        end
    endgenerate

    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = b;
            F3_H:    r = h;
            F3_BU:   r = {24'd0, b};
            F3_HU:   r = {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    logic                  ready_q;
    logic [ADDR_WIDTH-1:0] addr_p0;
    logic [IDX_W-1:0]      idx_p0;
    logic [1:0]            off_p0;
    logic [2:0]            f3_p0;
    logic                  we_p0;
    logic                  acc_p0;
    logic                  mis_p0;
    logic                  bad_f3_p0;
    logic                  oor_p0;
    logic                  err_p0;
    logic                  wr_p0;
    logic [3:0]            be_p0;
    logic [31:0]           wlane_p0;

    assign bus.req_ready = ready_q;
    assign addr_p0       = bus.req_addr;
    assign idx_p0        = addr_p0[IDX_W+1:2];
    assign off_p0        = addr_p0[1:0];
    assign f3_p0         = bus.req_funct3;
    assign we_p0         = bus.req_we;
    assign acc_p0        = bus.req_valid && ready_q;
    // Any address bit above the word index would silently alias another word.
    assign oor_p0        = (addr_p0 >> (IDX_W + 2)) != '0;
    assign err_p0        = oor_p0 | mis_p0 | bad_f3_p0;
    assign wr_p0         = acc_p0 && we_p0 && !err_p0;

    always_comb begin
        mis_p0    = 1'b0;
        bad_f3_p0 = 1'b0;
        be_p0     = 4'b0000;
        wlane_p0  = bus.req_wdata;
        case (f3_p0)
            F3_B, F3_BU: begin
                be_p0    = 4'b0001 << off_p0;
                wlane_p0 = {4{bus.req_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                mis_p0   = off_p0[0];
                be_p0    = off_p0[1] ? 4'b1100 : 4'b0011;
                wlane_p0 = {2{bus.req_wdata[15:0]}};
            end
            F3_W: begin
                mis_p0 = off_p0 != 2'd0;
                be_p0  = 4'b1111;
            end
            default: bad_f3_p0 = 1'b1;
        endcase
        if (we_p0 && (f3_p0 == F3_BU || f3_p0 == F3_HU)) begin
            bad_f3_p0 = 1'b1;
        end
    end

    // ---- stage p0 -> p1: array access on the acceptance edge ----
    logic [3:0][7:0] mem [DEPTH_WORDS];
    logic [31:0]     word_p1;
    logic            vld_p1;
    logic            ld_p1;
    logic            err_p1;
    logic [2:0]      f3_p1;
    logic [1:0]      off_p1;
    logic [31:0]     load_p1;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_p0 && be_p0[i]) begin
                mem[idx_p0][i] <= wlane_p0[8*i +: 8];
            end
        end
        if (acc_p0) begin
            word_p1 <= mem[idx_p0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            vld_p1  <= acc_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_p0) begin
            ld_p1  <= !we_p0;
            err_p1 <= err_p0;
            f3_p1  <= f3_p0;
            off_p1 <= off_p0;
        end
    end

    assign load_p1 = (ld_p1 && !err_p1) ? extend_load(word_p1, f3_p1, off_p1) : 32'd0;

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            // ---- stage p1 -> p2: selected/extended data registered ----
            logic        vld_p2;
            logic        ld_p2;
            logic        err_p2;
            logic [31:0] rdata_p2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p2 <= 1'b0;
                end else begin
                    vld_p2 <= vld_p1;
                end
            end

            always_ff @(posedge clk) begin
                if (vld_p1) begin
                    ld_p2    <= ld_p1;
                    err_p2   <= err_p1;
                    rdata_p2 <= load_p1;
                end
            end

            assign bus.resp_valid   = vld_p2;
            assign bus.resp_is_load = vld_p2 & ld_p2;
            assign bus.resp_err     = vld_p2 & err_p2;
            assign bus.resp_rdata   = vld_p2 ? rdata_p2 : 32'd0;
        end else begin : g_lat1
            assign bus.resp_valid   = vld_p1;
            assign bus.resp_is_load = vld_p1 & ld_p1;
            assign bus.resp_err     = vld_p1 & err_p1;
            assign bus.resp_rdata   = vld_p1 ? load_p1 : 32'd0;
        end
    endgenerate
endmodule

// File: tb/tb_data_mem_be.sv
// Directed bench driving identical traffic into a 1-cycle and a 2-cycle data memory
// and checking every response slot of both against hand-computed expectations.
module tb_data_mem_be;
    localparam int AW = 32;
    localparam int DW = 64;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    typedef struct packed {
        logic        is_load;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_be_if #(.ADDR_WIDTH(AW)) bus1 ();
    data_mem_be_if #(.ADDR_WIDTH(AW)) bus2 ();

    data_mem_be #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DW), .READ_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    data_mem_be #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DW), .READ_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    exp_t exp1[int];
    exp_t exp2[int];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        bus1.req_valid = v; bus1.req_we = we; bus1.req_funct3 = f3;
        bus1.req_addr  = a; bus1.req_wdata = wd;
        bus2.req_valid = v; bus2.req_we = we; bus2.req_funct3 = f3;
        bus2.req_addr  = a; bus2.req_wdata = wd;
    endtask

    // Called at a falling edge; the request is accepted on the next rising edge.
    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        set_req(1'b1, we, f3, a, wd);
        e.is_load = !we;
        e.err     = exp_err;
        e.rdata   = exp_rd;
        exp1[edge_n + 1] = e;
        exp2[edge_n + 2] = e;
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        drive(we, f3, a, wd, exp_rd, exp_err);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        repeat (n) @(negedge clk);
    endtask

    task automatic slot(input string tag, input bit hit, input exp_t e, input logic v,
                        input logic il, input logic er, input logic [31:0] rd);
        check({tag, ".valid"}, 32'(v), 32'(hit));
        if (hit) begin
            check({tag, ".is_load"}, 32'(il), 32'(e.is_load));
            check({tag, ".err"}, 32'(er), 32'(e.err));
            check({tag, ".rdata"}, rd, e.rdata);
        end else begin
            check({tag, ".idle_rdata"}, rd, 32'd0);
        end
    endtask

    task automatic monitor();
        exp_t e1, e2;
        bit   h1, h2;
        e1 = '0;
        e2 = '0;
        h1 = exp1.exists(edge_n);
        h2 = exp2.exists(edge_n);
        if (h1) begin e1 = exp1[edge_n]; exp1.delete(edge_n); end
        if (h2) begin e2 = exp2[edge_n]; exp2.delete(edge_n); end
        slot($sformatf("lat1@%0d", edge_n), h1, e1, bus1.resp_valid, bus1.resp_is_load,
             bus1.resp_err, bus1.resp_rdata);
        slot($sformatf("lat2@%0d", edge_n), h2, e2, bus2.resp_valid, bus2.resp_is_load,
             bus2.resp_err, bus2.resp_rdata);
    endtask

    always @(negedge clk) if (mon_en) monitor();

    initial begin
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        check("rst.ready1", 32'(bus1.req_ready), 32'd0);
        check("rst.ready2", 32'(bus2.req_ready), 32'd0);
        check("rst.valid1", 32'(bus1.resp_valid), 32'd0);
        check("rst.valid2", 32'(bus2.resp_valid), 32'd0);
        check("rst.is_load1", 32'(bus1.resp_is_load), 32'd0);
        check("rst.err2", 32'(bus2.resp_err), 32'd0);
        check("rst.rdata1", bus1.resp_rdata, 32'd0);
        rst_n = 1'b1;
        #1;
        check("release.ready1", 32'(bus1.req_ready), 32'd0);
        @(negedge clk);
        check("first_edge.ready1", 32'(bus1.req_ready), 32'd1);
        check("first_edge.ready2", 32'(bus2.req_ready), 32'd1);
        mon_en = 1'b1;

        // word store then load
        issue(1'b1, W, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        issue(1'b0, W, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);

        // byte lane store and extensions
        issue(1'b1, W, 32'h10, 32'h11223344, 32'd0, 1'b0);
        issue(1'b1, B, 32'h13, 32'h12345680, 32'd0, 1'b0);
        issue(1'b0, W, 32'h10, 32'd0, 32'h80223344, 1'b0);
        issue(1'b0, B, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0);
        issue(1'b0, BU, 32'h13, 32'd0, 32'h00000080, 1'b0);
        issue(1'b0, B, 32'h10, 32'd0, 32'h00000044, 1'b0);
        issue(1'b0, H, 32'h10, 32'd0, 32'h00003344, 1'b0);
        issue(1'b0, H, 32'h12, 32'd0, 32'hFFFF8022, 1'b0);

        // half store in the upper lanes
        issue(1'b1, W, 32'h20, 32'h01020304, 32'd0, 1'b0);
        issue(1'b1, H, 32'h22, 32'h7777A5A5, 32'd0, 1'b0);
        issue(1'b0, H, 32'h22, 32'd0, 32'hFFFFA5A5, 1'b0);
        issue(1'b0, HU, 32'h22, 32'd0, 32'h0000A5A5, 1'b0);
        issue(1'b0, HU, 32'h20, 32'd0, 32'h00000304, 1'b0);
        issue(1'b0, W, 32'h20, 32'd0, 32'hA5A50304, 1'b0);

        // error cases must neither write nor return data
        issue(1'b1, W, 32'h30, 32'hCAFEF00D, 32'd0, 1'b0);
        issue(1'b1, W, 32'h44, 32'h00000055, 32'd0, 1'b0);
        issue(1'b1, W, 32'hFC, 32'h5A5A5A5A, 32'd0, 1'b0);
        issue(1'b1, W, 32'h31, 32'hFFFFFFFF, 32'd0, 1'b1);
        issue(1'b1, H, 32'h31, 32'hFFFFFFFF, 32'd0, 1'b1);
        issue(1'b0, H, 32'h33, 32'd0, 32'd0, 1'b1);
        issue(1'b0, W, 32'h32, 32'd0, 32'd0, 1'b1);
        issue(1'b0, 3'b011, 32'h30, 32'd0, 32'd0, 1'b1);
        issue(1'b0, 3'b110, 32'h30, 32'd0, 32'd0, 1'b1);
        issue(1'b0, 3'b111, 32'h30, 32'd0, 32'd0, 1'b1);
        issue(1'b1, BU, 32'h30, 32'hFFFFFFFF, 32'd0, 1'b1);
        issue(1'b1, HU, 32'h30, 32'hFFFFFFFF, 32'd0, 1'b1);
        issue(1'b1, W, 32'h130, 32'hFFFFFFFF, 32'd0, 1'b1);
        issue(1'b0, W, 32'h130, 32'd0, 32'd0, 1'b1);
        issue(1'b0, W, 32'h80000030, 32'd0, 32'd0, 1'b1);
        issue(1'b0, W, 32'h30, 32'd0, 32'hCAFEF00D, 1'b0);
        issue(1'b0, W, 32'hFC, 32'd0, 32'h5A5A5A5A, 1'b0);

        // back-to-back stream with an idle slot
        issue(1'b1, W, 32'h40, 32'h89ABCDEF, 32'd0, 1'b0);
        issue(1'b0, W, 32'h40, 32'd0, 32'h89ABCDEF, 1'b0);
        issue(1'b0, W, 32'h44, 32'd0, 32'h00000055, 1'b0);
        idle(1);
        issue(1'b0, B, 32'h40, 32'd0, 32'hFFFFFFEF, 1'b0);
        issue(1'b0, B, 32'h41, 32'd0, 32'hFFFFFFCD, 1'b0);
        issue(1'b0, BU, 32'h42, 32'd0, 32'h000000AB, 1'b0);
        issue(1'b0, H, 32'h42, 32'd0, 32'hFFFF89AB, 1'b0);
        idle(3);

        // reset with two loads in flight
        issue(1'b0, W, 32'h10, 32'd0, 32'h80223344, 1'b0);
        drive(1'b0, W, 32'h20, 32'd0, 32'hA5A50304, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp1.delete();
        exp2.delete();
        #1;
        check("inflight.valid1", 32'(bus1.resp_valid), 32'd0);
        check("inflight.valid2", 32'(bus2.resp_valid), 32'd0);
        check("inflight.ready1", 32'(bus1.req_ready), 32'd0);
        check("inflight.rdata2", bus2.resp_rdata, 32'd0);
        set_req(1'b1, 1'b1, W, 32'h40, 32'hBAD0BAD0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rerelease.ready2", 32'(bus2.req_ready), 32'd0);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
        @(negedge clk);
        check("rerelease.ready1", 32'(bus1.req_ready), 32'd1);
        check("rerelease.ready2b", 32'(bus2.req_ready), 32'd1);
        issue(1'b0, W, 32'h40, 32'd0, 32'h89ABCDEF, 1'b0);
        issue(1'b0, W, 32'h10, 32'd0, 32'h80223344, 1'b0);
        issue(1'b0, W, 32'h30, 32'd0, 32'hCAFEF00D, 1'b0);
        issue(1'b0, HU, 32'hFE, 32'd0, 32'h00005A5A, 1'b0);
        idle(4);

        check("drain.lat1", 32'(exp1.num()), 32'd0);
        check("drain.lat2", 32'(exp2.num()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_be.md
Name: data_mem_be

Overview:
- Byte-addressed, byte-lane-enabled data memory for the RISC-V load/store path.
- Executes SB/SH/SW and LB/LH/LW/LBU/LHU directly from funct3: lane steering, sign/zero extension, misalignment and range checking.
- Valid/ready request port; response pipeline with configurable read latency (1 or 2 cycles).
- Sits between the core's memory stage and writeback; generalises the single-cycle word-only data memory.

Parameters:
- ADDR_WIDTH, 32, width of the byte address on req_addr.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥4.
- READ_LATENCY, 1, cycles from request acceptance to resp_valid. Legal values are 1 or 2; any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  32  store data; the low bytes are used for SB/SH.
- resp_valid  out  1  one-cycle response pulse per accepted request.
- resp_is_load  out  1  response belongs to a load.
- resp_rdata  out  32  extended load data; 0 for stores and for errors.
- resp_err  out  1  misaligned, illegal funct3 or out-of-range access.

Behaviour:
- Acceptance:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - req_ready is registered: 0 while in reset and on the first edge after rst_n deasserts, then constantly 1 (one request per cycle, no backpressure).
- Addressing:
  - Word index = req_addr[log2(DEPTH_WORDS)+1:2]; byte offset = req_addr[1:0].
  - Any set bit in req_addr above the word index is out of range and raises an error.
- Error checks (all produce resp_err=1, no memory write, resp_rdata=0):
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - funct3 ∈ {011, 110, 111}.
  - Store with funct3 100 or 101.
- Stores (lane mapping):
  - SB writes lane offset with wdata[7:0].
  - SH writes lanes {offset+1, offset} with wdata[15:0].
  - SW writes all four lanes.
  - Unselected lanes are unchanged.
  - The write commits on the acceptance edge.
- Loads:
  - The array is read on the acceptance edge.
  - The byte or half is selected by offset.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
- Latency:
  - resp_valid, resp_is_load, resp_rdata and resp_err appear exactly READ_LATENCY cycles after acceptance.
  - Responses are in order, one per accepted request.
  - With READ_LATENCY=2 the extension/selection is registered in the second stage.
- Ordering:
  - A load accepted on any cycle after a store's acceptance edge returns the stored data (no stale reads).
  - Back-to-back store→load to the same word must hit.
- Memory array: never reset; contents are undefined until written. A single-port array inferred as block RAM with byte enables.
- Reset (asynchronous, rst_n low):
  - Output values: req_ready=0, resp_valid=0, resp_is_load=0, resp_rdata=0, resp_err=0.
  - Pipeline valids are cleared immediately; in-flight responses are discarded.
  - No write occurs on any edge while rst_n=0.
  - Array contents survive reset.
- Idle cycles (no acceptance): resp_valid=0 in the corresponding response slot; resp_rdata/resp_err are driven to 0 whenever resp_valid=0.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 (LAT=1) → resp_valid one cycle after the load, rdata=0xDEADBEEF, err=0.
- SB 0x80 @0x13 over 0x11223344 → LW @0x10 gives 0x80223344; LB @0x13 gives 0xFFFFFF80; LBU @0x13 gives 0x00000080.
- SH 0xA5A5 @0x22, then LH @0x22 → 0xFFFFA5A5; LHU → 0x0000A5A5; the lower half of word 0x20 is unchanged.
- Misaligned SW @0x31, LH @0x33, funct3=011, out-of-range address → each gives resp_err=1, rdata=0; a following LW @0x30 shows the prior contents unchanged.
- READ_LATENCY=2, back-to-back stream SW@0x40, LW@0x40, LW@0x44, idle, LB@0x40 → four responses, in order, each exactly 2 cycles after acceptance; resp_valid=0 in the idle slot.
- Reset pulse with two loads in flight → resp_valid=0 immediately and never asserted for them; req_ready=0 until one edge after release; earlier-written data is still readable after reset.
